// File: rtl/fpga_status_led_ctrl_if.sv
// Control and status bundle for the board status LED block: per-channel
// mode/rate/event inputs, the exit-code override handshake and the LED/status outputs.
interface fpga_status_led_ctrl_if #(
  parameter int NUM_LEDS = 4
);
  logic [2*NUM_LEDS-1:0] mode_i;
  logic [2*NUM_LEDS-1:0] rate_i;
  logic [NUM_LEDS-1:0]   event_i;
  logic                  exit_valid_i;
  logic [31:0]           exit_value_i;
  logic                  clear_exit_i;
  logic [NUM_LEDS-1:0]   led_o;
  logic                  heartbeat_o;
  logic                  exit_latched_o;
  logic                  exit_fail_o;

  modport master (
    output mode_i, rate_i, event_i, exit_valid_i, exit_value_i, clear_exit_i,
    input  led_o, heartbeat_o, exit_latched_o, exit_fail_o
  );

  modport slave (
    input  mode_i, rate_i, event_i, exit_valid_i, exit_value_i, clear_exit_i,
    output led_o, heartbeat_o, exit_latched_o, exit_fail_o
  );
endinterface

// File: rtl/fpga_status_led_ctrl.sv
// Multi-channel status LED driver: off/on/blink/pulse-stretch per channel, with a
// latched program-exit override that shows pass (steady) or fail (blinking code).
module fpga_status_led_ctrl #(
  parameter int NUM_LEDS       = 4,
  parameter int PRESCALE_WIDTH = 27,
  parameter int STRETCH_CYCLES = 2**20
) (
  input  logic                 clk_gen,
  input  logic                 rst_n,
  fpga_status_led_ctrl_if.slave bus
);
  localparam int              SW           = $clog2(STRETCH_CYCLES + 1);
  localparam logic [SW-1:0]   STRETCH_LOAD = SW'(STRETCH_CYCLES);

  typedef enum logic {EXIT_IDLE, EXIT_LATCHED} exit_state_t;

  logic [PRESCALE_WIDTH-1:0] cnt;
  logic [3:0]                blink_taps;
  logic [SW-1:0]             stretch_q   [NUM_LEDS];
  logic [SW-1:0]             stretch_nxt [NUM_LEDS];
  exit_state_t               exit_state, exit_state_nxt;
  logic [NUM_LEDS-1:0]       code_q, code_nxt;
  logic                      fail_q, fail_nxt;
  logic [NUM_LEDS-1:0]       chan_led, led_d, led_q;

  // blink_taps[r] is the square wave for rate r; rate 0 is the prescaler MSB.
  assign blink_taps = {cnt[PRESCALE_WIDTH-4], cnt[PRESCALE_WIDTH-3],
                       cnt[PRESCALE_WIDTH-2], cnt[PRESCALE_WIDTH-1]};

  // NOTE: every sequential process uses non-blocking assignments so all registers
  // sample the same pre-edge values.
  always_ff @(posedge clk_gen or negedge rst_n) begin
    if (!rst_n) cnt <= '0;
    else        cnt <= cnt + PRESCALE_WIDTH'(1);
  end

  always_comb begin
    for (int i = 0; i < NUM_LEDS; i++) begin
      // NOTE: defaults first so no path through the case leaves a latch behind.
      stretch_nxt[i] = '0;
      chan_led[i]    = 1'b0;
      case (bus.mode_i[2*i +: 2])
        2'b01:   chan_led[i] = 1'b1;
        2'b10:   chan_led[i] = blink_taps[bus.rate_i[2*i +: 2]];
        2'b11: begin
          if (bus.event_i[i])            stretch_nxt[i] = STRETCH_LOAD;
          else if (stretch_q[i] != '0)   stretch_nxt[i] = stretch_q[i] - SW'(1);
          // Driving from the updated count gives exactly STRETCH_CYCLES on-edges.
          chan_led[i] = (stretch_nxt[i] != '0);
        end
        default: chan_led[i] = 1'b0;
      endcase
    end
  end

  always_comb begin
    exit_state_nxt = exit_state;
    code_nxt       = code_q;
    fail_nxt       = fail_q;
    case (exit_state)
      EXIT_IDLE: begin
        // Clear dominates a simultaneous exit flag; a still-high flag latches next cycle.
        if (!bus.clear_exit_i && bus.exit_valid_i) begin
          exit_state_nxt = EXIT_LATCHED;
          code_nxt       = bus.exit_value_i[NUM_LEDS-1:0];
          fail_nxt       = |bus.exit_value_i;
        end
      end
      EXIT_LATCHED: begin
        if (bus.clear_exit_i) begin
          exit_state_nxt = EXIT_IDLE;
          code_nxt       = '0;
          fail_nxt       = 1'b0;
        end
      end
      default: exit_state_nxt = EXIT_IDLE;
    endcase
  end

  always_comb begin
    led_d = chan_led;
    if (exit_state_nxt == EXIT_LATCHED)
      led_d = fail_nxt ? (code_nxt & {NUM_LEDS{cnt[PRESCALE_WIDTH-1]}}) : '1;
  end

  // NOTE: the stretch counters are a handful of flops, not a RAM, so they take the
  // async reset like any other state.
  always_ff @(posedge clk_gen or negedge rst_n) begin
    if (!rst_n) begin
      exit_state <= EXIT_IDLE;
      code_q     <= '0;
      fail_q     <= 1'b0;
      led_q      <= '0;
      for (int i = 0; i < NUM_LEDS; i++) stretch_q[i] <= '0;
    end else begin
      exit_state <= exit_state_nxt;
      code_q     <= code_nxt;
      fail_q     <= fail_nxt;
      led_q      <= led_d;
      for (int i = 0; i < NUM_LEDS; i++) stretch_q[i] <= stretch_nxt[i];
    end
  end

  assign bus.led_o          = led_q;
  assign bus.heartbeat_o    = cnt[PRESCALE_WIDTH-1];
  assign bus.exit_latched_o = (exit_state == EXIT_LATCHED);
  assign bus.exit_fail_o    = fail_q;
endmodule

// File: tb/tb_fpga_status_led_ctrl.sv
// Scoreboard bench for fpga_status_led_ctrl: the driver pushes model expectations per
// edge, an independent monitor pops and compares after every rising edge.
module tb_fpga_status_led_ctrl;
  localparam int NL  = 4;
  localparam int PW  = 4;
  localparam int SC  = 5;
  localparam int INF = 1000;

  typedef struct packed {
    logic [NL-1:0] led;
    logic          hb;
    logic          lat;
    logic          fail;
  } exp_t;

  logic clk_gen = 1'b0;
  logic rst_n   = 1'b0;
  always #5 clk_gen = ~clk_gen;

  fpga_status_led_ctrl_if #(.NUM_LEDS(NL)) bus ();

  fpga_status_led_ctrl #(
    .NUM_LEDS(NL), .PRESCALE_WIDTH(PW), .STRETCH_CYCLES(SC)
  ) dut (
    .clk_gen(clk_gen),
    .rst_n  (rst_n),
    .bus    (bus.slave)
  );

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  // Reference model state: cycle count since reset, cycles since the last
  // uninterrupted stretch trigger per channel, and the exit override.
  int            m_cnt;
  int            m_age [NL];
  bit            m_lat;
  logic [NL-1:0] m_code;
  bit            m_fail;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_cnt  = 0;
    for (int i = 0; i < NL; i++) m_age[i] = INF;
    m_lat  = 0;
    m_code = '0;
    m_fail = 0;
  endtask

  // Drives one cycle of inputs (called at a falling edge), records the expected
  // outputs after the next rising edge, then advances to the next falling edge.
  task automatic step(input logic [2*NL-1:0] mode, input logic [2*NL-1:0] rate,
                      input logic [NL-1:0] ev, input logic valid,
                      input logic [31:0] value, input logic clear);
    exp_t e;
    int   phase;
    bit   blink;
    bus.mode_i       = mode;
    bus.rate_i       = rate;
    bus.event_i      = ev;
    bus.exit_valid_i = valid;
    bus.exit_value_i = value;
    bus.clear_exit_i = clear;

    if (clear) begin
      m_lat = 0; m_code = '0; m_fail = 0;
    end else if (!m_lat && valid) begin
      m_lat = 1; m_code = value[NL-1:0]; m_fail = (value != 0);
    end

    phase = m_cnt % (1 << PW);
    for (int i = 0; i < NL; i++) begin
      int md = int'(mode[2*i +: 2]);
      int rt = int'(rate[2*i +: 2]);
      if (md != 3)   m_age[i] = INF;
      else if (ev[i]) m_age[i] = 0;
      else if (m_age[i] < INF) m_age[i] = m_age[i] + 1;
      blink = ((phase / (1 << (PW - 1 - rt))) % 2) == 1;
      case (md)
        0:       e.led[i] = 1'b0;
        1:       e.led[i] = 1'b1;
        2:       e.led[i] = blink;
        default: e.led[i] = (m_age[i] < SC);
      endcase
    end
    if (m_lat) e.led = m_fail ? (phase >= (1 << (PW - 1)) ? m_code : '0) : '1;

    m_cnt  = (m_cnt + 1) % (1 << PW);
    e.hb   = (m_cnt >= (1 << (PW - 1)));
    e.lat  = m_lat;
    e.fail = m_fail;
    exp_q.push_back(e);
    @(negedge clk_gen);
  endtask

  task automatic idle(input int n, input logic [2*NL-1:0] mode, input logic [2*NL-1:0] rate);
    for (int k = 0; k < n; k++) step(mode, rate, '0, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_led"},  32'(bus.led_o), 32'h0);
    check({tag, "_hb"},   32'(bus.heartbeat_o), 32'h0);
    check({tag, "_lat"},  32'(bus.exit_latched_o), 32'h0);
    check({tag, "_fail"}, 32'(bus.exit_fail_o), 32'h0);
  endtask

  // Monitor: after each rising edge out of reset, compare against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk_gen);
      #1;
      if (rst_n && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("led",          32'(bus.led_o),          32'(e.led));
        check("heartbeat",    32'(bus.heartbeat_o),    32'(e.hb));
        check("exit_latched", 32'(bus.exit_latched_o), 32'(e.lat));
        check("exit_fail",    32'(bus.exit_fail_o),    32'(e.fail));
      end
    end
  end

  initial begin
    bus.mode_i = '0; bus.rate_i = '0; bus.event_i = '0;
    bus.exit_valid_i = 1'b0; bus.exit_value_i = '0; bus.clear_exit_i = 1'b0;
    model_reset();
    repeat (3) @(posedge clk_gen);
    #1 check_all_zero("reset");

    @(negedge clk_gen);
    rst_n = 1'b1;

    // Steady on for a full heartbeat period.
    idle(18, 8'h55, 8'h00);
    // ch0 blink rate 0, ch1 blink rate 1, ch2 off, ch3 blink rate 3.
    idle(20, 8'h8A, 8'hC4);

    // ch2 stretch: single pulse, retrigger, mode drop mid-stretch, held event.
    step(8'h30, 8'h00, 4'b0100, 1'b0, 32'h0, 1'b0);
    idle(7, 8'h30, 8'h00);
    step(8'h30, 8'h00, 4'b0100, 1'b0, 32'h0, 1'b0);
    idle(2, 8'h30, 8'h00);
    step(8'h30, 8'h00, 4'b0100, 1'b0, 32'h0, 1'b0);
    idle(8, 8'h30, 8'h00);
    step(8'h30, 8'h00, 4'b0100, 1'b0, 32'h0, 1'b0);
    idle(2, 8'h30, 8'h00);
    idle(3, 8'h00, 8'h00);
    for (int k = 0; k < 8; k++) step(8'h30, 8'h00, 4'b0100, 1'b0, 32'h0, 1'b0);
    idle(6, 8'h30, 8'h00);

    // Pass exit: steady all-ones; later code changes ignored.
    step(8'h00, 8'h00, '0, 1'b1, 32'h0, 1'b0);
    for (int k = 0; k < 4; k++) step(8'h8A, 8'h00, '0, 1'b1, 32'h6, 1'b0);
    step(8'h00, 8'h00, '0, 1'b0, 32'h0, 1'b1);
    idle(2, 8'h55, 8'h00);

    // Fail exit with visible code, then fail with only upper bits set.
    step(8'h55, 8'h00, '0, 1'b1, 32'h6, 1'b0);
    idle(20, 8'h55, 8'h00);
    step(8'h55, 8'h00, '0, 1'b0, 32'h0, 1'b1);
    step(8'h55, 8'h00, '0, 1'b1, 32'h100, 1'b0);
    idle(6, 8'h55, 8'h00);
    step(8'h55, 8'h00, '0, 1'b0, 32'h0, 1'b1);

    // Clear and exit together, then exit held: drop, then re-latch.
    step(8'h00, 8'h00, '0, 1'b1, 32'h3, 1'b0);
    step(8'h00, 8'h00, '0, 1'b1, 32'h5, 1'b1);
    step(8'h00, 8'h00, '0, 1'b1, 32'h5, 1'b0);
    idle(3, 8'h00, 8'h00);
    step(8'h00, 8'h00, '0, 1'b0, 32'h0, 1'b1);

    // Active stretch plus latched pass exit, then asynchronous reset with no clock edge.
    step(8'h30, 8'h00, 4'b0100, 1'b1, 32'h0, 1'b0);
    step(8'h30, 8'h00, 4'b0000, 1'b0, 32'h0, 1'b0);
    @(posedge clk_gen);
    #2;
    rst_n = 1'b0;
    #1 check_all_zero("async_rst");
    @(posedge clk_gen);
    #1 check_all_zero("rst_held");
    exp_q.delete();
    model_reset();
    @(negedge clk_gen);
    rst_n = 1'b1;

    // Randomized traffic against the model.
    for (int k = 0; k < 400; k++) begin
      logic [31:0] val;
      case ($urandom_range(0, 3))
        0:       val = 32'h0;
        1:       val = 32'($urandom_range(1, 15));
        2:       val = 32'h100 << $urandom_range(0, 20);
        default: val = $urandom;
      endcase
      step(8'($urandom), 8'($urandom),
           ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0,
           ($urandom_range(0, 15) == 0), val,
           ($urandom_range(0, 9) == 0));
    end

    @(posedge clk_gen);
    #2;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
